// File: rtl/reg_file_w5.sv
// reg_file_w5 -- 32 x 32 MIPS general-purpose register file.
//
// Two combinational read ports (rs/rt) and one write port fed by the 5-bit
// destination-register select. Register 0 reads as zero and ignores writes.
// Optional write-through bypass forwards a same-cycle write to the read ports.
// A debug scoreboard records which registers have been written since reset
// and counts committed writes (saturating).
//
// Ports:
//   clk           system clock, rising-edge state updates
//   rst_n         asynchronous active-low reset (clears all state)
//   reg_write     write enable
//   write_reg     destination register number
//   write_data    write-back data
//   read_reg1/2   rs / rt read addresses
//   read_data1/2  rs / rt read data (combinational)
//   written_mask  bit i set once register i has been written since reset
//   write_count   committed writes since reset, saturates at 16'hFFFF
module reg_file_w5 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   reg_write,
  input  logic [ADDR_W-1:0]      write_reg,
  input  logic [DATA_W-1:0]      write_data,
  input  logic [ADDR_W-1:0]      read_reg1,
  input  logic [ADDR_W-1:0]      read_reg2,
  output logic [DATA_W-1:0]      read_data1,
  output logic [DATA_W-1:0]      read_data2,
  output logic [(2**ADDR_W)-1:0] written_mask,
  output logic [15:0]            write_count
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  written_mask_q, written_mask_d;
  logic [15:0]       write_count_q, write_count_d;

  logic             wr_en;
  logic [DEPTH-1:0] wr_sel;

  // reg_write gates first so an unknown write_reg cannot leak into wr_en
  // while writes are disabled.
  assign wr_en = reg_write && (write_reg != '0);

  always_comb begin
    wr_sel = '0;
    if (wr_en) begin
      wr_sel[write_reg] = 1'b1;
    end
  end

  always_comb begin
    regs_d         = regs_q;
    written_mask_d = written_mask_q | wr_sel;
    write_count_d  = write_count_q;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        regs_d[i] = write_data;
      end
    end
    if (wr_en && (write_count_q != '1)) begin
      write_count_d = write_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      written_mask_q <= '0;
      write_count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      written_mask_q <= written_mask_d;
      write_count_q  <= write_count_d;
    end
  end

  // Address 0 is forced to zero ahead of the bypass so r0 never forwards.
  always_comb begin
    if (read_reg1 == '0) begin
      read_data1 = '0;
    end else if (BYPASS && wr_en && (write_reg == read_reg1)) begin
      read_data1 = write_data;
    end else begin
      read_data1 = regs_q[read_reg1];
    end
  end

  always_comb begin
    if (read_reg2 == '0) begin
      read_data2 = '0;
    end else if (BYPASS && wr_en && (write_reg == read_reg2)) begin
      read_data2 = write_data;
    end else begin
      read_data2 = regs_q[read_reg2];
    end
  end

  assign written_mask = written_mask_q;
  assign write_count  = write_count_q;

endmodule

// File: tb/tb_reg_file_w5.sv
// Scoreboard bench for reg_file_w5: a bypassing and a non-bypassing instance
// share one set of inputs; stimulus queues expectations, a monitor compares.
module tb_reg_file_w5;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [31:0] mask_b, mask_n;
  logic [15:0] cnt_b, cnt_n;

  reg_file_w5 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_b), .read_data2(rd2_b), .written_mask(mask_b),
    .write_count(cnt_b));

  reg_file_w5 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(rd1_n), .read_data2(rd2_n), .written_mask(mask_n),
    .write_count(cnt_n));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef enum int {K_RD1, K_RD2, K_MASK, K_CNT, K_NB_RD1, K_NB_RD2, K_NB_MASK, K_NB_CNT} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: one sample #1 after expectations appear, then compare them all.
  initial begin
    chk_t        c;
    logic [31:0] act;
    forever begin
      wait (q.size() != 0);
      #1;
      while (q.size() != 0) begin
        c = q.pop_front();
        case (c.kind)
          K_RD1:     act = rd1_b;
          K_RD2:     act = rd2_b;
          K_MASK:    act = mask_b;
          K_CNT:     act = {16'd0, cnt_b};
          K_NB_RD1:  act = rd1_n;
          K_NB_RD2:  act = rd2_n;
          K_NB_MASK: act = mask_n;
          default:   act = {16'd0, cnt_n};
        endcase
        n_checks++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input kind_t k, input logic [31:0] e, input string nm);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.name = nm;
    q.push_back(c);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 20) begin
      #1;
      t++;
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL monitor_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  localparam logic [31:0] M8_31 = (32'd1 << 8) | (32'd1 << 31);

  initial begin
    rst_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0;

    // reset state
    expect_val(K_RD1, 32'd0, "reset_rd1");
    expect_val(K_MASK, 32'd0, "reset_mask");
    expect_val(K_CNT, 32'd0, "reset_cnt");
    drain();
    cyc();
    rst_n = 1'b1;

    // load r5, then asynchronous reset pulse between edges
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
    cyc();
    reg_write = 1'b0; read_reg1 = 5'd5;
    expect_val(K_RD1, 32'hDEADBEEF, "r5_loaded");
    expect_val(K_CNT, 32'd1, "r5_cnt");
    drain();
    #1;
    rst_n = 1'b0;
    expect_val(K_RD1, 32'd0, "async_reset_rd1");
    expect_val(K_NB_RD1, 32'd0, "async_reset_nb_rd1");
    expect_val(K_MASK, 32'd0, "async_reset_mask");
    expect_val(K_CNT, 32'd0, "async_reset_cnt");
    drain();
    rst_n = 1'b1;
    cyc();

    // write / read r8 and r31
    reg_write = 1'b1; write_reg = 5'd8; write_data = 32'h12345678;
    cyc();
    write_reg = 5'd31; write_data = 32'hFFFF0000;
    cyc();
    reg_write = 1'b0; read_reg1 = 5'd8; read_reg2 = 5'd31;
    expect_val(K_RD1, 32'h12345678, "rd_r8");
    expect_val(K_RD2, 32'hFFFF0000, "rd_r31");
    expect_val(K_NB_RD1, 32'h12345678, "nb_rd_r8");
    expect_val(K_NB_RD2, 32'hFFFF0000, "nb_rd_r31");
    expect_val(K_MASK, M8_31, "mask_8_31");
    expect_val(K_CNT, 32'd2, "cnt_2");
    drain();

    // write to r0 is dropped, including through the bypass
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'hAAAAAAAA;
    read_reg1 = 5'd0; read_reg2 = 5'd0;
    expect_val(K_RD1, 32'd0, "r0_bypass_rd1");
    expect_val(K_RD2, 32'd0, "r0_bypass_rd2");
    drain();
    cyc();
    reg_write = 1'b0;
    expect_val(K_RD1, 32'd0, "r0_after");
    expect_val(K_MASK, M8_31, "r0_mask");
    expect_val(K_CNT, 32'd2, "r0_cnt");
    drain();

    // bypass vs no bypass on r3
    reg_write = 1'b1; write_reg = 5'd3; write_data = 32'd1;
    cyc();
    write_data = 32'h55; read_reg1 = 5'd3; read_reg2 = 5'd3;
    expect_val(K_RD1, 32'h55, "byp_rd1");
    expect_val(K_RD2, 32'h55, "byp_rd2");
    expect_val(K_NB_RD1, 32'd1, "nobyp_rd1_old");
    expect_val(K_NB_RD2, 32'd1, "nobyp_rd2_old");
    drain();
    cyc();
    reg_write = 1'b0;
    expect_val(K_RD1, 32'h55, "byp_rd1_after");
    expect_val(K_NB_RD1, 32'h55, "nobyp_rd1_after");
    expect_val(K_NB_RD2, 32'h55, "nobyp_rd2_after");
    expect_val(K_CNT, 32'd4, "cnt_4");
    expect_val(K_NB_MASK, M8_31 | 32'h8, "nb_mask_3");
    drain();

    // write-enable gating
    reg_write = 1'b0; write_reg = 5'd9; write_data = 32'd7; read_reg1 = 5'd9;
    for (int i = 0; i < 10; i++) cyc();
    expect_val(K_RD1, 32'd0, "gated_r9");
    expect_val(K_MASK, M8_31 | 32'h8, "gated_mask");
    expect_val(K_CNT, 32'd4, "gated_cnt");
    drain();
    write_reg = 'x;
    for (int i = 0; i < 3; i++) cyc();
    expect_val(K_CNT, 32'd4, "x_addr_cnt");
    expect_val(K_NB_CNT, 32'd4, "x_addr_nb_cnt");
    drain();

    // saturation: 65536 writes to r1 on top of the 4 already counted
    reg_write = 1'b1; write_reg = 5'd1; read_reg1 = 5'd1;
    for (int i = 0; i < 65536; i++) begin
      write_data = 32'hA5A50000 ^ i;
      if (i == 65530) begin
        expect_val(K_CNT, 32'h0000FFFE, "cnt_fffe");
        drain();
      end
      if (i == 65531) begin
        expect_val(K_CNT, 32'h0000FFFF, "cnt_ffff");
        drain();
      end
      cyc();
    end
    reg_write = 1'b0;
    expect_val(K_CNT, 32'h0000FFFF, "cnt_saturated");
    expect_val(K_RD1, 32'hA5A5FFFF, "r1_last");
    expect_val(K_MASK, M8_31 | 32'h8 | 32'h2, "mask_final");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
